// File: rtl/demux8_buffered.sv
// Buffered 1-to-8 stream demultiplexer.
// One input channel is steered by select into eight 1-entry lane registers, each with its own valid/ready.
module demux8_buffered #(
    parameter int unsigned Size = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          select,
    input  logic [Size-1:0]     data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [8*Size-1:0]   data_o,
    output logic [7:0]          valid_o,
    input  logic [7:0]          ready_i,
    output logic [3:0]          occupancy
);

    localparam int unsigned Lanes = 8;
    localparam int unsigned OccW  = 4;

    logic             accept;
    logic [Lanes-1:0] fill;
    logic [Lanes-1:0] drain;
    logic [Lanes-1:0] valid_nxt;
    logic [OccW-1:0]  occ_nxt;

    // Target lane can take a word if it is empty or being drained this edge.
    always_comb begin
        ready_o = ~valid_o[select] | ready_i[select];
        accept  = valid_i & ready_o;
    end

    // Per-lane fill/drain decode and next-state valid vector.
    always_comb begin
        fill  = '0;
        drain = valid_o & ready_i;
        for (int unsigned k = 0; k < Lanes; k++) begin
            fill[k] = accept && (select == 3'(k));
        end
        valid_nxt = (valid_o & ~drain) | fill;
    end

    // Occupancy is kept as the popcount of the next valid vector so it tracks valid_o exactly.
    always_comb begin
        occ_nxt = '0;
        for (int unsigned k = 0; k < Lanes; k++) begin
            occ_nxt = occ_nxt + OccW'(valid_nxt[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_o   <= '0;
            data_o    <= '0;
            occupancy <= '0;
        end else begin
            valid_o   <= valid_nxt;
            occupancy <= occ_nxt;
            for (int unsigned k = 0; k < Lanes; k++) begin
                if (fill[k]) begin
                    data_o[k*Size +: Size] <= data_i;
                end
            end
        end
    end

endmodule
